// File: rtl/osd_spi_pkg.sv
// Shared types and OSD command encodings for the OSD SPI master.
package osd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] OSD_CMD_OFF    = 8'h40;
  localparam logic [7:0] OSD_CMD_ON     = 8'h41;
  localparam logic [7:0] OSD_CMD_WRLINE = 8'h20;

  function automatic logic [7:0] wrline_cmd(input logic [2:0] row);
    return OSD_CMD_WRLINE | {5'b00000, row};
  endfunction

endpackage

// File: rtl/osd_spi_clkdiv.sv
// SCK half-period tick generator: one tick every CLK_DIV enabled cycles,
// restartable with a synchronous clear.
module osd_spi_clkdiv #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/osd_spi_tx.sv
// SPI mode-0 master for the mixer OSD port: one command byte plus 0..MAX_LEN
// payload bytes per transaction. Define OSD_SPI_TX_SWAP_EN to add the `swap`
// input, which sends payload bytes LSB first.
module osd_spi_tx
  import osd_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 256,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       cmd,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       data,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic             SPI_SCK,
  output logic             SPI_SS3,
  output logic             SPI_DI
`ifdef OSD_SPI_TX_SWAP_EN
  ,
  input  logic             swap
`endif
);

  localparam logic [3:0]  LAST_BIT  = 4'hF;
  localparam logic [16:0] STALL_MAX = 17'(256 * CLK_DIV);

  state_t           state, state_nx;
  logic             tick, div_clr;
  logic [7:0]       shreg, pay;
  logic [3:0]       bitcnt;
  logic [LEN_W-1:0] remaining, len_sat;
  logic             loaded;
  logic [16:0]      stall_cnt;
  logic             accept, sck_rise, sck_fall, shift_en, consume, consume_next;
  logic             to_next, to_hold, release_ss, stall;

`ifdef OSD_SPI_TX_SWAP_EN
  function automatic logic [7:0] bit_reverse(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  logic swap_q;
  always_ff @(posedge clk_sys) begin
    if (accept) swap_q <= swap;
  end
  assign pay = swap_q ? bit_reverse(data) : data;
`else
  assign pay = data;
`endif

  assign len_sat    = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign busy       = (state != IDLE);
  assign data_ready = consume;
  // A byte taken after a stall gets a fresh full low half-period before SCK rises.
  assign div_clr    = (state == IDLE) || consume_next;

  osd_spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk   (clk_sys),
    .reset (reset),
    .en    (state != IDLE),
    .clr   (div_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    sck_rise     = 1'b0;
    sck_fall     = 1'b0;
    shift_en     = 1'b0;
    consume      = 1'b0;
    consume_next = 1'b0;
    to_next      = 1'b0;
    to_hold      = 1'b0;
    release_ss   = 1'b0;
    stall        = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (tick) state_nx = SHIFT;
      end
      SHIFT: begin
        if (tick && !SPI_SCK) begin
          sck_rise = 1'b1;
        end else if (tick) begin
          sck_fall = 1'b1;
          // The low half-period after the last bit doubles as setup for the next byte.
          if (bitcnt != LAST_BIT) begin
            shift_en = 1'b1;
          end else if (remaining == '0) begin
            to_hold  = 1'b1;
            state_nx = HOLD;
          end else if (data_valid) begin
            consume = 1'b1;
          end else begin
            to_next  = 1'b1;
            state_nx = NEXT;
          end
        end
      end
      NEXT: begin
        if (!loaded) begin
          if (data_valid) begin
            consume      = 1'b1;
            consume_next = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end else if (tick) begin
          state_nx = SHIFT;
        end
      end
      HOLD: begin
        if (tick) begin
          release_ss = 1'b1;
          state_nx   = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      SPI_SCK   <= 1'b0;
      SPI_SS3   <= 1'b1;
      SPI_DI    <= 1'b0;
      underrun  <= 1'b0;
      loaded    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (accept) begin
        SPI_SS3  <= 1'b0;
        SPI_DI   <= cmd[7];
        underrun <= 1'b0;
      end
      if (sck_rise)   SPI_SCK <= 1'b1;
      if (sck_fall)   SPI_SCK <= 1'b0;
      if (shift_en)   SPI_DI  <= shreg[6];
      if (consume)    SPI_DI  <= pay[7];
      if (to_hold)    SPI_DI  <= 1'b0;
      if (release_ss) SPI_SS3 <= 1'b1;
      if (to_next)    loaded  <= 1'b0;
      if (consume) begin
        loaded    <= 1'b1;
        stall_cnt <= '0;
      end
      if (stall) begin
        if (stall_cnt == STALL_MAX) underrun  <= 1'b1;
        else                        stall_cnt <= stall_cnt + 17'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (accept) begin
      shreg     <= cmd;
      bitcnt    <= 4'd7;
      remaining <= len_sat;
    end
    if (sck_rise) bitcnt <= bitcnt - 4'd1;
    if (shift_en) shreg  <= {shreg[6:0], 1'b0};
    if (consume) begin
      shreg     <= pay;
      bitcnt    <= 4'd7;
      remaining <= remaining - LEN_W'(1);
    end
  end

endmodule
